// File: rtl/countdown_timer_pkg.sv
// Types and helpers shared by countdown_timer and its tick prescaler.
package countdown_timer_pkg;
`include "common.vh"

  typedef enum logic [1:0] {
    S_IDLE = TIMER_ST_IDLE,
    S_RUN  = TIMER_ST_RUN,
    S_DONE = TIMER_ST_DONE
  } state_t;

  // A single-cycle prescaler still gets a 1-bit counter so the port list stays uniform.
  function automatic int unsigned prescale_cnt_w(input int unsigned p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction
endpackage

// File: rtl/common.vh
// Shared counter width and timer state encodings, reused by status readback logic.
`ifndef COMMON_VH
`define COMMON_VH
`define COUNTER_WIDTH 10
localparam logic [1:0] TIMER_ST_IDLE = 2'd0;
localparam logic [1:0] TIMER_ST_RUN  = 2'd1;
localparam logic [1:0] TIMER_ST_DONE = 2'd2;
`endif

// File: rtl/countdown_timer_tick_prescaler.sv
// Divides CLK into one-cycle ticks every PRESCALE enabled cycles; clear restarts the phase.
module tick_prescaler
  import countdown_timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int unsigned   CW   = prescale_cnt_w(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  // With PRESCALE=1 the counter never leaves zero, so tick follows enable directly.
  assign tick = enable && (cnt == LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause/abort and a one-cycle done pulse on expiry.
// Define TIMER_AUTORELOAD_EN to restart from the loaded value on expiry instead of stopping.
`include "common.vh"
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH    = `COUNTER_WIDTH,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load_valid_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic             load_ready_o,
  input  logic             pause_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             done_o
);
  state_t           state;
  logic [WIDTH-1:0] count_q;
  logic             done_q;
  logic             tick;
  logic             presc_en;
  logic             presc_clr;
`ifdef TIMER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q;
`endif

  assign presc_en  = (state == S_RUN) && !pause_i;
  assign presc_clr = (state != S_RUN) || abort_i;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .CLK    (CLK),
    .RST    (RST),
    .enable (presc_en),
    .clear  (presc_clr),
    .tick   (tick)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= S_IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_valid_i) begin
            if (load_value_i != '0) begin
              count_q <= load_value_i;
`ifdef TIMER_AUTORELOAD_EN
              reload_q <= load_value_i;
`endif
              state   <= S_RUN;
            end else begin
              // A zero load expires immediately without ever entering RUN.
              done_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (abort_i) begin
            count_q <= '0;
            state   <= S_IDLE;
          end else if (tick) begin
            if (count_q == WIDTH'(1)) begin
              done_q <= 1'b1;
`ifdef TIMER_AUTORELOAD_EN
              count_q <= reload_q;
`else
              count_q <= '0;
              state   <= S_DONE;
`endif
            end else begin
              count_q <= count_q - WIDTH'(1);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign load_ready_o = (state == S_IDLE);
  assign busy_o       = (state == S_RUN);
  assign count_o      = count_q;
  assign done_o       = done_q;
endmodule
